// File: rtl/pc_gen_if.sv
// Fetch-side bus for pc_gen: redirect/trap/stall controls in, per-hart PC and fault status out.
interface pc_gen_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_HARTS = 1
);
    localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_req;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [HW-1:0]   hart_id;
    logic            misaligned;
    logic [XLEN-1:0] bad_target;

    modport master (
        output stall, redirect_valid, redirect_pc, trap_req,
        input  pc, pc_valid, hart_id, misaligned, bad_target
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, trap_req,
        output pc, pc_valid, hart_id, misaligned, bad_target
    );
endinterface

// File: rtl/pc_gen.sv
// Multi-hart round-robin program-counter generator with boot hold and misaligned-redirect trapping.
// Optional PC_COMPRESSED_EN relaxes redirect alignment to 2 bytes.
module pc_gen #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] BASE_PC     = '0,
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100),
    parameter int unsigned     NUM_HARTS   = 1,
    parameter int unsigned     BOOT_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t          r_state,      w_state_nxt;
    logic [3:0]      r_boot_cnt,   w_boot_cnt_nxt;
    logic [XLEN-1:0] r_pcs         [NUM_HARTS];
    logic [XLEN-1:0] w_pcs_nxt     [NUM_HARTS];
    logic [HW-1:0]   r_hart_id,    w_hart_nxt, w_hart_inc;
    logic            r_pc_valid;
    logic            r_misaligned, w_mis_nxt;
    logic [XLEN-1:0] r_bad_target, w_bad_nxt;
    logic            w_target_bad;

`ifdef PC_COMPRESSED_EN
    assign w_target_bad = bus.redirect_pc[0];
`else
    assign w_target_bad = |bus.redirect_pc[1:0];
`endif

    // Single-hart builds collapse to a constant 0 since the last index is 0.
    assign w_hart_inc = (r_hart_id == HW'(NUM_HARTS - 1)) ? '0 : r_hart_id + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        w_pcs_nxt      = r_pcs;
        w_hart_nxt     = r_hart_id;
        w_mis_nxt      = 1'b0;
        w_bad_nxt      = r_bad_target;
        case (r_state)
            S_BOOT: begin
                if (r_boot_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt - 4'd1;
                end
            end
            S_RUN: begin
                if (bus.trap_req) begin
                    w_pcs_nxt[r_hart_id] = TRAP_VEC;
                end else if (bus.redirect_valid) begin
                    if (w_target_bad) begin
                        w_pcs_nxt[r_hart_id] = TRAP_VEC;
                        w_bad_nxt            = bus.redirect_pc;
                        w_mis_nxt            = 1'b1;
                    end else begin
                        w_pcs_nxt[r_hart_id] = bus.redirect_pc;
                    end
                end else if (!bus.stall) begin
                    w_pcs_nxt[r_hart_id] = r_pcs[r_hart_id] + XLEN'(4);
                end
                // Trap/redirect still land under stall, but the hart only rotates when not stalled.
                if (!bus.stall) begin
                    w_hart_nxt = w_hart_inc;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_boot_cnt   <= 4'(BOOT_CYCLES);
            r_hart_id    <= '0;
            r_pc_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bad_target <= '0;
            for (int unsigned i = 0; i < NUM_HARTS; i++) begin
                r_pcs[i] <= BASE_PC;
            end
        end else begin
            r_boot_cnt   <= w_boot_cnt_nxt;
            r_hart_id    <= w_hart_nxt;
            r_pc_valid   <= (w_state_nxt == S_RUN);
            r_misaligned <= w_mis_nxt;
            r_bad_target <= w_bad_nxt;
            for (int unsigned i = 0; i < NUM_HARTS; i++) begin
                r_pcs[i] <= w_pcs_nxt[i];
            end
        end
    end

    assign bus.pc         = r_pcs[r_hart_id];
    assign bus.pc_valid   = r_pc_valid;
    assign bus.hart_id    = r_hart_id;
    assign bus.misaligned = r_misaligned;
    assign bus.bad_target = r_bad_target;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: single-hart, zero-boot and three-hart instances on a shared clock/reset.
module tb_pc_gen;
    logic clk;
    logic rst;

    pc_gen_if #(.XLEN(32), .NUM_HARTS(1)) b1 ();
    pc_gen_if #(.XLEN(32), .NUM_HARTS(1)) b0 ();
    pc_gen_if #(.XLEN(32), .NUM_HARTS(3)) b3 ();

    pc_gen #(.XLEN(32), .NUM_HARTS(1), .BOOT_CYCLES(2)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    pc_gen #(.XLEN(32), .NUM_HARTS(1), .BOOT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    pc_gen #(.XLEN(32), .NUM_HARTS(3), .BOOT_CYCLES(2)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  hart;
        logic        valid;
        logic        mis;
        logic [31:0] bad;
        logic [31:0] pc0;
        logic        valid0;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_bad1 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, tests run %0d", n_tests);
        $fatal(1);
    end

    task automatic set1(input logic tr, input logic rv, input logic [31:0] rp, input logic st);
        b1.trap_req = tr; b1.redirect_valid = rv; b1.redirect_pc = rp; b1.stall = st;
    endtask

    task automatic set3(input logic tr, input logic rv, input logic [31:0] rp, input logic st);
        b3.trap_req = tr; b3.redirect_valid = rv; b3.redirect_pc = rp; b3.stall = st;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        set1(0, 0, '0, 0);
        set3(0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1;
        if (b1.pc !== 32'h0)       begin n_fail++; $display("FAIL reset_pc: got %h want 0", b1.pc); end
        if (b1.pc_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", b1.pc_valid); end
        if (b1.hart_id !== 1'b0)   begin n_fail++; $display("FAIL reset_hart: got %b want 0", b1.hart_id); end
        if (b1.misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", b1.misaligned); end
        if (b1.bad_target !== 32'h0) begin n_fail++; $display("FAIL reset_bad: got %h want 0", b1.bad_target); end
        n_tests += 5;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e = '{pc: (k < 3) ? 32'h0 : 32'(4 * (k - 2)), hart: 2'd0, valid: (k >= 2),
                  mis: 1'b0, bad: 32'h0, pc0: 32'(4 * k), valid0: 1'b1};
            q.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (b1.pc !== e.pc)          begin n_fail++; $display("FAIL boot_pc[%0d]: got %h want %h", k, b1.pc, e.pc); end
            if (b1.pc_valid !== e.valid) begin n_fail++; $display("FAIL boot_valid[%0d]: got %b want %b", k, b1.pc_valid, e.valid); end
            if (b1.misaligned !== e.mis) begin n_fail++; $display("FAIL boot_mis[%0d]: got %b want %b", k, b1.misaligned, e.mis); end
            if (b0.pc !== e.pc0)         begin n_fail++; $display("FAIL boot0_pc[%0d]: got %h want %h", k, b0.pc, e.pc0); end
            if (b0.pc_valid !== e.valid0) begin n_fail++; $display("FAIL boot0_valid[%0d]: got %b want %b", k, b0.pc_valid, e.valid0); end
            n_tests += 5;
        end
    endtask

    task automatic test_priority();
        exp_t        e;
        logic        tr [4];
        logic        rv [4];
        logic        st [4];
        logic [31:0] ep [4];
        tr = '{1'b1, 1'b0, 1'b0, 1'b0};
        rv = '{1'b1, 1'b1, 1'b0, 1'b0};
        st = '{1'b1, 1'b1, 1'b1, 1'b0};
        ep = '{32'h0000_0100, 32'h0000_2000, 32'h0000_2000, 32'h0000_2004};
        for (int i = 0; i < 4; i++) begin
            set1(tr[i], rv[i], 32'h0000_2000, st[i]);
            q.push_back('{pc: ep[i], hart: 2'd0, valid: 1'b1, mis: 1'b0, bad: exp_bad1, pc0: '0, valid0: 1'b0});
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (b1.pc !== e.pc)          begin n_fail++; $display("FAIL prio_pc[%0d]: got %h want %h", i, b1.pc, e.pc); end
            if (b1.pc_valid !== e.valid) begin n_fail++; $display("FAIL prio_valid[%0d]: got %b want %b", i, b1.pc_valid, e.valid); end
            if (b1.misaligned !== e.mis) begin n_fail++; $display("FAIL prio_mis[%0d]: got %b want %b", i, b1.misaligned, e.mis); end
            if (b1.bad_target !== e.bad) begin n_fail++; $display("FAIL prio_bad[%0d]: got %h want %h", i, b1.bad_target, e.bad); end
            n_tests += 4;
        end
        set1(0, 0, '0, 0);
    endtask

    task automatic test_misaligned();
        exp_t        e;
        logic        rv [5];
        logic [31:0] rp [5];
        logic [31:0] ep [5];
        logic        em [5];
        logic [31:0] eb [5];
        rv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rp = '{32'h1000_000A, 32'h0, 32'h0000_0003, 32'h0000_0006, 32'h0};
`ifdef PC_COMPRESSED_EN
        ep = '{32'h1000_000A, 32'h1000_000E, 32'h0000_0100, 32'h0000_0006, 32'h0000_000A};
        em = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        eb = '{32'h0, 32'h0, 32'h3, 32'h3, 32'h3};
`else
        ep = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        em = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        eb = '{32'h1000_000A, 32'h1000_000A, 32'h3, 32'h6, 32'h6};
`endif
        for (int i = 0; i < 5; i++) begin
            set1(1'b0, rv[i], rp[i], 1'b0);
            q.push_back('{pc: ep[i], hart: 2'd0, valid: 1'b1, mis: em[i], bad: eb[i], pc0: '0, valid0: 1'b0});
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (b1.pc !== e.pc)          begin n_fail++; $display("FAIL mis_pc[%0d]: got %h want %h", i, b1.pc, e.pc); end
            if (b1.misaligned !== e.mis) begin n_fail++; $display("FAIL mis_pulse[%0d]: got %b want %b", i, b1.misaligned, e.mis); end
            if (b1.bad_target !== e.bad) begin n_fail++; $display("FAIL mis_bad[%0d]: got %h want %h", i, b1.bad_target, e.bad); end
            n_tests += 3;
            exp_bad1 = e.bad;
        end
        set1(0, 0, '0, 0);
    endtask

    task automatic test_wrap();
        exp_t        e;
        logic        rv [3];
        logic [31:0] ep [3];
        rv = '{1'b1, 1'b0, 1'b0};
        ep = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        for (int i = 0; i < 3; i++) begin
            set1(1'b0, rv[i], 32'hFFFF_FFFC, 1'b0);
            q.push_back('{pc: ep[i], hart: 2'd0, valid: 1'b1, mis: 1'b0, bad: exp_bad1, pc0: '0, valid0: 1'b0});
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (b1.pc !== e.pc)          begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, b1.pc, e.pc); end
            if (b1.misaligned !== e.mis) begin n_fail++; $display("FAIL wrap_mis[%0d]: got %b want %b", i, b1.misaligned, e.mis); end
            if (b1.bad_target !== e.bad) begin n_fail++; $display("FAIL wrap_bad[%0d]: got %h want %h", i, b1.bad_target, e.bad); end
            n_tests += 3;
        end
        set1(0, 0, '0, 0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        set1(1'b0, 1'b1, 32'h0000_2000, 1'b0);
        @(posedge clk);
        #1;
        if (b1.pc !== 32'h0000_2000) begin n_fail++; $display("FAIL mid_pre_pc: got %h want 00002000", b1.pc); end
        n_tests++;
        set1(0, 0, '0, 0);
        #3;
        rst = 1'b1;
        #1;
        if (b1.pc !== 32'h0)         begin n_fail++; $display("FAIL mid_pc: got %h want 0", b1.pc); end
        if (b1.pc_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_valid: got %b want 0", b1.pc_valid); end
        if (b1.hart_id !== 1'b0)     begin n_fail++; $display("FAIL mid_hart: got %b want 0", b1.hart_id); end
        if (b1.bad_target !== 32'h0) begin n_fail++; $display("FAIL mid_bad: got %h want 0", b1.bad_target); end
        n_tests += 4;
        exp_bad1 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // trap and redirect are held through boot and must be ignored there
        for (int k = 0; k < 4; k++) begin
            if (k < 3) set1(1'b1, 1'b1, 32'h0000_2000, 1'b0);
            else       set1(0, 0, '0, 0);
            q.push_back('{pc: (k < 3) ? 32'h0 : 32'h4, hart: 2'd0, valid: (k >= 2), mis: 1'b0,
                          bad: 32'h0, pc0: '0, valid0: 1'b0});
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (b1.pc !== e.pc)          begin n_fail++; $display("FAIL reboot_pc[%0d]: got %h want %h", k, b1.pc, e.pc); end
            if (b1.pc_valid !== e.valid) begin n_fail++; $display("FAIL reboot_valid[%0d]: got %b want %b", k, b1.pc_valid, e.valid); end
            if (b1.misaligned !== e.mis) begin n_fail++; $display("FAIL reboot_mis[%0d]: got %b want %b", k, b1.misaligned, e.mis); end
            n_tests += 3;
        end
        set1(0, 0, '0, 0);
    endtask

    task automatic test_multi_hart();
        exp_t        e;
        logic        st  [14];
        logic        tr  [14];
        logic        rv  [14];
        logic [1:0]  eh  [14];
        logic [31:0] epc [14];
        st  = '{0,0,0,0,0,0,0,0,1,1,1,1,0,0};
        tr  = '{0,0,0,0,0,0,0,0,0,0,1,0,0,0};
        rv  = '{0,0,0,0,0,0,0,0,0,0,1,1,0,0};
        eh  = '{2'd0,2'd0,2'd0,2'd1,2'd2,2'd0,2'd1,2'd2,2'd2,2'd2,2'd2,2'd2,2'd0,2'd1};
        epc = '{32'h0,32'h0,32'h0,32'h0,32'h0,32'h4,32'h4,32'h4,32'h4,32'h4,
                32'h100,32'h2000,32'h8,32'h8};
        set3(0, 0, '0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            set3(tr[i], rv[i], 32'h0000_2000, st[i]);
            q.push_back('{pc: epc[i], hart: eh[i], valid: (i >= 2), mis: 1'b0, bad: 32'h0, pc0: '0, valid0: 1'b0});
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (b3.hart_id !== e.hart)   begin n_fail++; $display("FAIL mh_hart[%0d]: got %0d want %0d", i, b3.hart_id, e.hart); end
            if (b3.pc !== e.pc)          begin n_fail++; $display("FAIL mh_pc[%0d]: got %h want %h", i, b3.pc, e.pc); end
            if (b3.pc_valid !== e.valid) begin n_fail++; $display("FAIL mh_valid[%0d]: got %b want %b", i, b3.pc_valid, e.valid); end
            n_tests += 3;
        end
        set3(0, 0, '0, 0);
    endtask

    initial begin
        b0.trap_req = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_pc = '0; b0.stall = 1'b0;
        test_reset();
        test_priority();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_multi_hart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator replacing the single fixed-reset PC register in the fetch stage. Holds one PC per hardware thread (barrel-style round-robin), and resolves each cycle in priority order: trap, redirect, stall, sequential advance. Runs a boot-hold counter after reset before issuing fetches. Detects misaligned redirect targets and vectors them to the trap handler, capturing the faulting target.

## Interface
Parameters:
- `XLEN`, 32, PC width in bits (≥ 16).
- `BASE_PC`, 32'h0000_0000, reset PC loaded into every hart.
- `TRAP_VEC`, 32'h0000_0100, PC loaded on trap or misaligned redirect; must be 4-byte aligned.
- `NUM_HARTS`, 1, number of hart PC contexts, 1–4.
- `BOOT_CYCLES`, 2, cycles `pc_valid` stays low after reset release, 0–15.

Ports:
- `clk`, in, 1, rising-edge clock.
- `rst`, in, 1, asynchronous active-high reset.
- `stall`, in, 1, hold the current state; no PC or hart change.
- `redirect_valid`, in, 1, load `redirect_pc` into the active hart.
- `redirect_pc`, in, XLEN, branch/jump target.
- `trap_req`, in, 1, load `TRAP_VEC` into the active hart.
- `pc`, out, XLEN, registered PC of the active hart.
- `pc_valid`, out, 1, `pc` is a legal fetch address.
- `hart_id`, out, max(1, $clog2(NUM_HARTS)), active hart index.
- `misaligned`, out, 1, registered one-cycle pulse on a rejected redirect.
- `bad_target`, out, XLEN, last rejected redirect target.

## Operation
- State machine with states BOOT and RUN. Reset puts the block in BOOT and loads the boot counter with `BOOT_CYCLES`.
- BOOT: the counter decrements each cycle and `stall` is ignored. When the counter is 0 the next state is RUN. With `BOOT_CYCLES`=0, BOOT lasts exactly one cycle. No PC updates occur in BOOT; `trap_req` and `redirect_valid` are ignored.
- RUN, per cycle, with "active" meaning the hart at `hart_id`. The first matching rule applies:
  1. `trap_req`: active PC ← `TRAP_VEC`.
  2. `redirect_valid` with an aligned target: active PC ← `redirect_pc`.
  3. `redirect_valid` with a misaligned target: active PC ← `TRAP_VEC`, `bad_target` ← `redirect_pc`, `misaligned` pulses for 1 cycle.
  4. `stall`: nothing changes, including `hart_id`.
  5. Otherwise: active PC ← PC + 4, computed modulo 2^XLEN (wraps to 0).
- Hart rotation: in RUN, whenever `stall` is low, `hart_id` advances (N−1 wraps to 0) in the same cycle as rules 1, 2, 3 or 5. With `NUM_HARTS`=1, `hart_id` is held at 0.
- `trap_req` and `redirect_valid` take effect even when `stall` is high. Rotation is still suppressed in that case.
- `pc` is the stored PC of the hart selected by the registered `hart_id`.
- Reset values: all hart PCs = `BASE_PC`, `hart_id`=0, `pc_valid`=0, `misaligned`=0, `bad_target`=0, state=BOOT.
- Reset asserted mid-operation clears everything asynchronously and immediately, regardless of state.

## Timing
- Every output is registered; nothing is combinational from an input to an output.
- Latency: an input sampled at edge N is visible on `pc`, `hart_id` and `misaligned` after edge N (1 cycle).
- Boot: `pc_valid` rises after the (`BOOT_CYCLES`+1)-th rising edge following reset deassertion. `pc` = `BASE_PC` throughout BOOT.
- Once in RUN, `pc_valid` stays 1 until the next reset.
- `misaligned` is high for exactly one cycle per rejected redirect. Back-to-back rejected redirects give back-to-back pulses, and `bad_target` updates each time.

## Configuration
- `PC_COMPRESSED_EN` defined:
  - A redirect is misaligned only if `redirect_pc[0]`=1.
  - `TRAP_VEC` and `BASE_PC` need only 2-byte alignment.
  - Sequential increment remains +4.
- `PC_COMPRESSED_EN` undefined: a redirect is misaligned if `redirect_pc[1:0]`≠0.

## Test plan
- Reset/boot:
  - Stimulus: `BOOT_CYCLES`=2, `BASE_PC`=0; hold `rst` for 2 cycles, then release.
  - Response: `pc`=0 and `pc_valid`=0 for the first 2 edges; `pc_valid`=1 after the 3rd edge; then `pc`=0x4, then 0x8.
- Priority:
  - Stimulus: in RUN, assert `trap_req`, `redirect_valid` (0x2000) and `stall` together.
  - Response: next `pc`=0x100, `hart_id` unchanged.
  - Stimulus: same with `trap_req` low.
  - Response: `pc`=0x2000.
- Misaligned redirect:
  - Stimulus: `redirect_pc`=0x1000_000A.
  - Response (macro undefined): `pc`=0x100, `misaligned`=1 for one cycle, `bad_target`=0x1000_000A.
  - Response (`PC_COMPRESSED_EN` defined): `pc`=0x1000_000A and no pulse.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFFC, then one free-running cycle.
  - Response: `pc`=0x0000_0000.
- Multi-hart:
  - Stimulus: `NUM_HARTS`=3, `BASE_PC`=0, free run for 6 cycles.
  - Response: `hart_id` sequence 0,1,2,0,1,2; `pc` sequence 0,0,0,4,4,4.
  - Stimulus: `stall` for 2 cycles.
  - Response: `hart_id` and `pc` frozen.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously between edges while `pc`=0x2000.
  - Response: `pc`=`BASE_PC`, `pc_valid`=0 and `hart_id`=0 before the next edge; boot sequence repeats.
